// File: rtl/p2s_rr_sched.sv
// Round-robin scheduler feeding one parallel-to-serial shifter: grants a requester,
// shifts its word out LSB-first followed by a parity bit, tagging each bit with the owner id.
module p2s_rr_sched #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int PAR_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  ser_data,
    output logic                  ser_valid,
    output logic                  ser_first,
    output logic                  ser_par,
    output logic [IDW-1:0]        ser_id,
    output logic                  busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAR   = 2'd2;

    function automatic logic frame_parity(input logic [WIDTH-1:0] w);
        return (^w) ^ (PAR_ODD != 0);
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] hold_q,      hold_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             parity_q,    parity_d;
    logic [IDW-1:0]   last_q,      last_d;
    logic [IDW-1:0]   ser_id_q,    ser_id_d;
    logic             ser_data_q,  ser_data_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_par_q,   ser_par_d;
    logic             busy_q,      busy_d;

    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic [NREQ-1:0]  grant_oh;
    logic [WIDTH-1:0] grant_word;

    // Arbiter: scan from the requester after the last winner, wrapping modulo NREQ.
    always_comb begin
        scan_idx   = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant_oh   = '0;
        grant_word = '0;
        if (state_q == IDLE) begin
            for (int k = 1; k <= NREQ; k++) begin
                scan_idx = IDW'((int'(last_q) + k) % NREQ);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
            if (grant_any) begin
                grant_oh[grant_idx] = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (grant_idx == IDW'(i)) begin
                    grant_word = req_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign req_ready = grant_oh;

    // Outputs are registered, so each branch computes what the next cycle will present.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        last_d      = last_q;
        ser_id_d    = ser_id_q;
        ser_data_d  = 1'b0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_par_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    hold_d      = grant_word;
                    ser_id_d    = grant_idx;
                    last_d      = grant_idx;
                    parity_d    = frame_parity(grant_word);
                    cnt_d       = '0;
                    state_d     = SHIFT;
                    ser_valid_d = 1'b1;
                    ser_first_d = 1'b1;
                    ser_data_d  = grant_word[0];
                end
            end
            SHIFT: begin
                hold_d      = hold_q >> 1;
                cnt_d       = cnt_q + 1'b1;
                ser_valid_d = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d    = PAR;
                    ser_par_d  = 1'b1;
                    ser_data_d = parity_q;
                end else begin
                    ser_data_d = hold_q[1];
                end
            end
            PAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            parity_q    <= 1'b0;
            last_q      <= IDW'(NREQ - 1);
            ser_id_q    <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_par_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            last_q      <= last_d;
            ser_id_q    <= ser_id_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_par_q   <= ser_par_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_par   = ser_par_q;
    assign ser_id    = ser_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_p2s_rr_sched.sv
// Directed bench for p2s_rr_sched: an even-parity instance for arbitration/framing
// and an odd-parity instance for the parity polarity cases.
module tb_p2s_rr_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        ser_data, ser_valid, ser_first, ser_par, busy;
    logic [1:0]  ser_id;

    logic [3:0]  o_valid;
    logic [15:0] o_data;
    logic [3:0]  o_ready;
    logic        o_ser_data, o_ser_valid, o_ser_first, o_ser_par, o_busy;
    logic [1:0]  o_ser_id;

    int n_total = 0;
    int n_pass  = 0;
    time t_prev, t_now;

    always #5 clk = ~clk;

    p2s_rr_sched #(.WIDTH(4), .NREQ(4), .IDW(2), .PAR_ODD(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_data(ser_data), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_par(ser_par), .ser_id(ser_id), .busy(busy)
    );

    p2s_rr_sched #(.WIDTH(4), .NREQ(4), .IDW(2), .PAR_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .req_valid(o_valid), .req_data(o_data),
        .req_ready(o_ready), .ser_data(o_ser_data), .ser_valid(o_ser_valid),
        .ser_first(o_ser_first), .ser_par(o_ser_par), .ser_id(o_ser_id), .busy(o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first data-bit cycle; returns in the parity cycle.
    task automatic frame_check(input logic [1:0] id, input logic [3:0] word, input logic par);
        for (int i = 0; i < 4; i++) begin
            chk("bit",      32'(ser_data),  32'(word[i]));
            chk("valid",    32'(ser_valid), 32'd1);
            chk("first",    32'(ser_first), (i == 0) ? 32'd1 : 32'd0);
            chk("parflag",  32'(ser_par),   32'd0);
            chk("id",       32'(ser_id),    32'(id));
            chk("busy",     32'(busy),      32'd1);
            chk("rdy_busy", 32'(req_ready), 32'd0);
            tick();
        end
        chk("par",    32'(ser_data),  32'(par));
        chk("pflag",  32'(ser_par),   32'd1);
        chk("pvalid", 32'(ser_valid), 32'd1);
        chk("pfirst", 32'(ser_first), 32'd0);
        chk("pid",    32'(ser_id),    32'(id));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; o_valid = '0; o_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ser_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_id",    32'(ser_id),    32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single request from requester 1, word 1011, even parity -> 1
        req_valid = 4'b0010; req_data = 16'h00B0;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        frame_check(2'd1, 4'b1011, 1'b1);
        tick();
        chk("single_idle_valid", 32'(ser_valid), 32'd0);
        chk("single_idle_busy",  32'(busy),      32'd0);

        // Reset in the middle of a frame from requester 3
        req_valid = 4'b1000; req_data = 16'h7000;
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(ser_valid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_par",   32'(ser_par),   32'd0);

        // Round robin with all four requesters held valid
        req_valid = 4'b1111; req_data = 16'h8421;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            t_now = $time;
            if (k > 0) chk("rr_period", 32'((t_now - t_prev) / 10), 32'd6);
            t_prev = t_now;
            frame_check(2'(k % 4), 4'(1 << (k % 4)), 1'b1);
            tick();
        end
        req_valid = '0;

        // Withdraw: req 2 drops before its turn, req 3 stays valid
        req_valid = 4'b1110; req_data = 16'h8521;
        #1;
        chk("wd_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        frame_check(2'd1, 4'h2, 1'b1);
        tick();
        chk("wd_ready3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        frame_check(2'd3, 4'h8, 1'b1);
        tick();
        chk("wd_idle_valid", 32'(ser_valid), 32'd0);
        chk("wd_idle_ready", 32'(req_ready), 32'd0);
        chk("wd_keep_id",    32'(ser_id),    32'd3);

        // Back-to-back: requester 0 re-asserts valid in its parity cycle
        req_valid = 4'b0001; req_data = 16'h0006;
        #1;
        chk("b2b_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        frame_check(2'd0, 4'b0110, 1'b0);
        req_valid = 4'b0001;
        t_prev = $time;
        tick();
        chk("b2b_gap_valid", 32'(ser_valid), 32'd0);
        chk("b2b_gap_busy",  32'(busy),      32'd0);
        chk("b2b_regrant",   32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("b2b_first", 32'(ser_first), 32'd1);
        chk("b2b_gap",   32'(($time - t_prev) / 10), 32'd2);
        frame_check(2'd0, 4'b0110, 1'b0);
        tick();

        // Odd parity instance: 0000 -> 1, 1111 -> 1
        for (int w = 0; w < 2; w++) begin
            o_valid = 4'b0001; o_data = (w == 0) ? 16'h0000 : 16'h000F;
            #1;
            chk("odd_ready", 32'(o_ready), 32'b0001);
            tick();
            o_valid = '0;
            chk("odd_first", 32'(o_ser_first), 32'd1);
            repeat (4) tick();
            chk("odd_parflag", 32'(o_ser_par),  32'd1);
            chk("odd_parity",  32'(o_ser_data), 32'd1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
